set_assoc_dcache: RTL
=====================

SET_ASSOC_DCACHE -- requirements
Module: set_assoc_dcache

Interface
REQ-001 The block SHALL have parameter NUM_WAYS, default 2, meaning ways per set (power of two, 1..4).
REQ-002 The block SHALL have parameter INDEX_BITS, default 2, meaning log2 of the set count.
REQ-003 The block SHALL have parameter OFFSET_BITS, default 2, meaning log2 of 32-bit words per line; legal values are 2, 3 and 4, mapping to MLEN4, MLEN8 and MLEN16.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port dreq, input, dbus_req_t: CPU request with fields valid, addr, size, strobe, data.
REQ-007 The block SHALL have port dresp, output, dbus_resp_t: CPU response with fields addr_ok, data_ok, data.
REQ-008 The block SHALL have port creq, output, cbus_req_t: memory burst request with fields valid, is_write, size, addr, strobe, data, len.
REQ-009 The block SHALL have port cresp, input, cbus_resp_t: memory response with fields ready, last, data.

Function
REQ-010 The block SHALL split addresses as follows: bits [1:0] are the byte offset, [OFFSET_BITS+1:2] the word offset, the next INDEX_BITS bits the set index, and the remaining upper bits the tag.
REQ-011 The block SHALL keep per line a valid bit, a dirty bit, a tag and the data words, stored in flip-flops.
REQ-012 The block SHALL keep per set a round-robin victim pointer.
REQ-013 The block SHALL implement an FSM with states IDLE, WRITEBACK and FETCH.
REQ-014 In IDLE, when dreq.valid is high, the block SHALL do a combinational lookup in all ways of the indexed set; a hit is a valid line with a matching tag.
REQ-015 On a hit, the block SHALL drive dresp.addr_ok=1 and dresp.data_ok=1 in the same cycle, with dresp.data equal to the addressed word (full word; size ignored for reads).
REQ-016 On a write hit (strobe nonzero), the block SHALL merge dreq.data into the addressed word byte-wise per strobe at the clock edge and set the line's dirty bit.
REQ-017 On a miss, the block SHALL keep addr_ok and data_ok at 0 and select the victim: the first invalid way (lowest index), else the way at the set's pointer.
REQ-018 After a miss, the FSM SHALL go to WRITEBACK if the victim is valid and dirty, else to FETCH.
REQ-019 In WRITEBACK, creq SHALL carry valid=1, is_write=1, size=MSIZE4, strobe=4'b1111, addr = victim line base, len per REQ-003, and data = victim word at the beat counter.
REQ-020 In WRITEBACK, the beat counter SHALL advance on cresp.ready; on cresp.ready && cresp.last the block SHALL clear the counter and go to FETCH.
REQ-021 In FETCH, creq SHALL carry valid=1, is_write=0, size=MSIZE4, strobe=0, addr = line base of dreq.addr, and len per REQ-003.
REQ-022 In FETCH, on each cresp.ready the block SHALL write cresp.data into victim word[counter] and advance the counter.
REQ-023 On the last FETCH beat, the block SHALL set valid=1, dirty=0 and the new tag, advance the set pointer modulo NUM_WAYS, and return to IDLE; the pending request then hits per REQ-015/016.
REQ-024 When cresp.ready is low, the beat counter and all creq fields SHALL hold.
REQ-025 creq fields other than valid SHALL be stable for the whole burst.
REQ-026 The block SHALL require the CPU to hold dreq stable until addr_ok is seen, and SHALL NOT latch dreq.
REQ-027 Outside WRITEBACK and FETCH, creq.valid SHALL be 0.
REQ-028 In IDLE with dreq.valid low, the block SHALL hold all state and keep addr_ok and data_ok at 0.

Reset
REQ-029 While resetn is low, immediately and regardless of clk, the block SHALL set the FSM to IDLE, the counter to 0, all valid and dirty bits and set pointers to 0, and all dresp and creq fields to 0.
REQ-030 Reset mid-burst SHALL abandon the burst: no partial line is marked valid and no writeback resumes; data array contents are don't-care.

Verification
Defaults throughout (2 ways, 4 sets, 4-word lines); memory model holds 0xDEADBEEF at 0x10.
REQ-031 Bench SHALL cover read miss: read 0x10 after reset -> read burst at addr 0x10 with MLEN4 and 4 beats, no write burst, then data_ok=1 with data 0xDEADBEEF.
REQ-032 Bench SHALL cover read hit: then read 0x14 -> addr_ok=data_ok=1 in the cycle dreq.valid rises, creq.valid stays 0.
REQ-033 Bench SHALL cover write hit with merge: write 0x10, data 0x12345678, strobe 4'b0011 -> hit, no creq; a later read of 0x10 returns 0xDEAD5678.
REQ-034 Bench SHALL cover dirty eviction: read 0x50 (fills way 1 of set 1), then read 0x90 -> write burst at 0x10 whose beat 0 is 0xDEAD5678, then read burst at 0x90, then data_ok.
REQ-035 Bench SHALL cover stall: hold cresp.ready low for 3 cycles mid-FETCH -> counter and creq fields unchanged, and the line completes correctly after ready resumes.
REQ-036 Bench SHALL cover reset mid-burst: drop resetn during FETCH beat 2 -> creq.valid=0 at once; after release, read 0x10 misses again with a full 4-beat burst.

Source files
------------

// File: rtl/set_assoc_dcache_pkg.sv
// Bus payload types shared by the data cache and its CPU / memory-side neighbours.
package set_assoc_dcache_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Burst length encoded as beats minus one
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic    valid;
    logic    is_write;
    msize_t  size;
    addr_t   addr;
    strobe_t strobe;
    word_t   data;
    mlen_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

endpackage

// File: rtl/set_assoc_dcache.sv
// Set-associative write-back data cache: flop-based storage, round-robin replacement,
// single-cycle hits and a writeback/fetch burst FSM toward memory.
module set_assoc_dcache
  import set_assoc_dcache_pkg::*;
#(
  parameter int unsigned NUM_WAYS    = 2,
  parameter int unsigned INDEX_BITS  = 2,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int unsigned NUM_SETS = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << OFFSET_BITS;
  localparam int unsigned WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned LINE_LSB = OFFSET_BITS + 2;
  localparam int unsigned TAG_LSB  = LINE_LSB + INDEX_BITS;
  localparam int unsigned TAG_BITS = 32 - TAG_LSB;
  localparam mlen_t       LEN      = (OFFSET_BITS == 2) ? MLEN4 :
                                     (OFFSET_BITS == 3) ? MLEN8 : MLEN16;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t                 state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic [WAY_BITS-1:0]    victim_q, victim_d;

  logic [31:0]         data_q  [NUM_SETS][NUM_WAYS][WORDS];
  logic [TAG_BITS-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic                valid_q [NUM_SETS][NUM_WAYS];
  logic                dirty_q [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0] ptr_q   [NUM_SETS];

  logic [INDEX_BITS-1:0]  idx_c;
  logic [TAG_BITS-1:0]    tag_c;
  logic [OFFSET_BITS-1:0] word_c;
  logic                   lookup_c;
  logic                   hit_c;
  logic [WAY_BITS-1:0]    hit_way_c;
  logic [WAY_BITS-1:0]    victim_c;
  logic                   found_inv_c;
  logic                   fill_done_c;
  logic                   unused_c;

  assign idx_c       = dreq.addr[LINE_LSB +: INDEX_BITS];
  assign tag_c       = dreq.addr[31:TAG_LSB];
  assign word_c      = dreq.addr[2 +: OFFSET_BITS];
  assign lookup_c    = (state_q == IDLE) && dreq.valid;
  assign fill_done_c = (state_q == FETCH) && cresp.ready && cresp.last;
  assign unused_c    = ^{dreq.size, dreq.addr[1:0]};

  // Tag match across the indexed set, plus victim choice (lowest invalid way, else pointer)
  always_comb begin
    hit_c       = 1'b0;
    hit_way_c   = '0;
    victim_c    = ptr_q[idx_c];
    found_inv_c = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!hit_c && valid_q[idx_c][WAY_BITS'(w)] && (tag_q[idx_c][WAY_BITS'(w)] == tag_c)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_BITS'(w);
      end
      if (!found_inv_c && !valid_q[idx_c][WAY_BITS'(w)]) begin
        found_inv_c = 1'b1;
        victim_c    = WAY_BITS'(w);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    victim_d = victim_q;
    dresp    = '0;
    creq     = '0;
    unique case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          if (hit_c) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = data_q[idx_c][hit_way_c][word_c];
          end else begin
            victim_d = victim_c;
            state_d  = (valid_q[idx_c][victim_c] && dirty_q[idx_c][victim_c]) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.size     = MSIZE4;
        creq.strobe   = 4'b1111;
        creq.addr     = {tag_q[idx_c][victim_q], idx_c, {LINE_LSB{1'b0}}};
        creq.data     = data_q[idx_c][victim_q][cnt_q];
        creq.len      = LEN;
        if (cresp.ready) begin
          cnt_d = cnt_q + OFFSET_BITS'(1);
          if (cresp.last) begin
            cnt_d   = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b0;
        creq.size     = MSIZE4;
        creq.strobe   = 4'b0000;
        creq.addr     = {tag_c, idx_c, {LINE_LSB{1'b0}}};
        creq.len      = LEN;
        if (cresp.ready) begin
          cnt_d = cnt_q + OFFSET_BITS'(1);
          if (cresp.last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
    end
  end

  // Line metadata; a line only becomes valid once its whole fill has landed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        ptr_q[s] <= '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
        end
      end
    end else begin
      if (lookup_c && hit_c && (dreq.strobe != 4'b0000)) begin
        dirty_q[idx_c][hit_way_c] <= 1'b1;
      end
      if (fill_done_c) begin
        valid_q[idx_c][victim_q] <= 1'b1;
        dirty_q[idx_c][victim_q] <= 1'b0;
        tag_q[idx_c][victim_q]   <= tag_c;
        ptr_q[idx_c] <= (ptr_q[idx_c] == WAY_BITS'(NUM_WAYS - 1)) ?
                        '0 : ptr_q[idx_c] + WAY_BITS'(1);
      end
    end
  end

  // Data words carry no reset: contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (lookup_c && hit_c) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (dreq.strobe[2'(b)]) begin
          data_q[idx_c][hit_way_c][word_c][8*b +: 8] <= dreq.data[8*b +: 8];
        end
      end
    end
    if ((state_q == FETCH) && cresp.ready) begin
      data_q[idx_c][victim_q][cnt_q] <= cresp.data;
    end
  end

endmodule
